cfs_md_realigner: RTL

//  Parametrised stream re-aligner for the MD protocol: packs legal RX transfers (arbitrary offset/size) into a byte FIFO.
//  Re-emits the bytes as TX transfers of a fixed configured offset/size.

---
 rtl/cfs_md_realigner.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/cfs_md_realigner.sv
// MD stream re-aligner: packs legal RX transfers into a byte FIFO and re-emits them at a fixed TX offset/size.
// Optional flush of a partial remainder when CFS_MD_REALIGNER_FLUSH_EN is defined (adds cfg_flush).
module cfs_md_realigner #(
  parameter int ALGN_DATA_WIDTH = 32,
  parameter int BUF_BYTES       = 16,
  parameter int CNT_DROP_WIDTH  = 8,
  localparam int NB = ALGN_DATA_WIDTH / 8,
  localparam int OW = (NB <= 1) ? 1 : $clog2(NB),
  localparam int SW = $clog2(NB) + 1,
  localparam int LW = $clog2(BUF_BYTES) + 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [OW-1:0]              cfg_offset,
  input  logic [SW-1:0]              cfg_size,
  input  logic                       cfg_clr_cnt,
`ifdef CFS_MD_REALIGNER_FLUSH_EN
  input  logic                       cfg_flush,
`endif
  input  logic                       md_rx_valid,
  input  logic [ALGN_DATA_WIDTH-1:0] md_rx_data,
  input  logic [OW-1:0]              md_rx_offset,
  input  logic [SW-1:0]              md_rx_size,
  output logic                       md_rx_ready,
  output logic                       md_rx_err,
  output logic                       md_tx_valid,
  output logic [ALGN_DATA_WIDTH-1:0] md_tx_data,
  output logic [OW-1:0]              md_tx_offset,
  output logic [SW-1:0]              md_tx_size,
  input  logic                       md_tx_ready,
  input  logic                       md_tx_err,
  output logic [CNT_DROP_WIDTH-1:0]  cnt_drop,
  output logic [LW-1:0]              buf_level,
  output logic                       irq
);

  localparam int PW = (BUF_BYTES <= 1) ? 1 : $clog2(BUF_BYTES);

  typedef enum logic [0:0] {ST_IDLE, ST_SEND} state_t;

  state_t                      state_r, state_nxt_s;
  logic [7:0]                  mem_r [BUF_BYTES];
  logic [7:0]                  mem_nxt_s [BUF_BYTES];
  logic [PW-1:0]               wr_ptr_r, rd_ptr_r, rd_base_s;
  logic [LW-1:0]               level_r, level_push_s, level_rem_s;
  logic [CNT_DROP_WIDTH-1:0]   cnt_r;
  logic                        irq_r;
  logic                        tx_valid_r, tx_valid_nxt_s;
  logic [ALGN_DATA_WIDTH-1:0]  tx_data_r, tx_data_nxt_s, ln_word_s, ln_data_s, rx_bytes_s;
  logic [OW-1:0]               tx_offset_r, tx_offset_nxt_s;
  logic [SW-1:0]               tx_size_r, tx_size_nxt_s, ln_size_s, push_cnt_s;
  logic                        rx_legal_s, rx_fit_s, rx_accept_s, rx_drop_s;
  logic                        cfg_legal_s, flush_ok_s, pop_s, launch_s, tx_err_s;

  assign rx_legal_s  = (md_rx_size != {SW{1'b0}}) &&
                       ((SW+1)'(md_rx_offset) + (SW+1)'(md_rx_size) <= (SW+1)'(NB));
  assign cfg_legal_s = (cfg_size != {SW{1'b0}}) &&
                       ((SW+1)'(cfg_offset) + (SW+1)'(cfg_size) <= (SW+1)'(NB));
  // Free space is judged on the start-of-cycle level only; a same-cycle pop gives no credit.
  assign rx_fit_s    = (LW'(BUF_BYTES) - level_r) >= LW'(md_rx_size);
  assign rx_accept_s = md_rx_valid && rx_legal_s && rx_fit_s;
  assign rx_drop_s   = md_rx_valid && !rx_legal_s;
  assign md_rx_ready = md_rx_valid && (!rx_legal_s || rx_fit_s);
  assign md_rx_err   = rx_drop_s;

  assign push_cnt_s   = rx_accept_s ? md_rx_size : {SW{1'b0}};
  assign pop_s        = tx_valid_r && md_tx_ready;
  assign tx_err_s     = pop_s && md_tx_err;
  assign level_push_s = level_r + LW'(push_cnt_s);
  assign level_rem_s  = level_r - LW'(tx_size_r);
  assign rd_base_s    = rd_ptr_r + (pop_s ? PW'(tx_size_r) : {PW{1'b0}});
  assign rx_bytes_s   = md_rx_data >> {md_rx_offset, 3'b000};

`ifdef CFS_MD_REALIGNER_FLUSH_EN
  assign flush_ok_s = cfg_flush && cfg_legal_s && (level_r != {LW{1'b0}}) && (level_r < LW'(cfg_size));
`else
  assign flush_ok_s = 1'b0;
`endif

  // Buffer contents after this cycle's push, so a launch can see bytes arriving now.
  always_comb begin
    mem_nxt_s = mem_r;
    for (int i = 0; i < NB; i++) begin
      mem_nxt_s[wr_ptr_r + PW'(i)] = (rx_accept_s && (SW'(i) < md_rx_size)) ?
                                     rx_bytes_s[8*i +: 8] : mem_nxt_s[wr_ptr_r + PW'(i)];
    end
  end

  // Launch decision: IDLE counts the incoming push, SEND counts only what remains after the pop.
  always_comb begin
    launch_s  = 1'b0;
    ln_size_s = cfg_size;
    case (state_r)
      ST_IDLE: begin
        if (cfg_legal_s && (level_push_s >= LW'(cfg_size))) begin
          launch_s = 1'b1;
        end else if (flush_ok_s) begin
          launch_s  = 1'b1;
          ln_size_s = SW'(level_r);
        end else begin
          launch_s = 1'b0;
        end
      end
      ST_SEND: begin
        if (md_tx_ready && cfg_legal_s && (level_rem_s >= LW'(cfg_size))) begin
          launch_s = 1'b1;
        end else begin
          launch_s = 1'b0;
        end
      end
      default: launch_s = 1'b0;
    endcase
  end

  // Oldest ln_size_s bytes packed from lane 0, then shifted up to the configured offset.
  always_comb begin
    ln_word_s = {ALGN_DATA_WIDTH{1'b0}};
    for (int i = 0; i < NB; i++) begin
      ln_word_s[8*i +: 8] = (SW'(i) < ln_size_s) ? mem_nxt_s[rd_base_s + PW'(i)] : 8'h00;
    end
    ln_data_s = ln_word_s << {cfg_offset, 3'b000};
  end

  // TX FSM next state and registered TX outputs.
  always_comb begin
    state_nxt_s     = state_r;
    tx_valid_nxt_s  = tx_valid_r;
    tx_data_nxt_s   = tx_data_r;
    tx_offset_nxt_s = tx_offset_r;
    tx_size_nxt_s   = tx_size_r;
    if (launch_s) begin
      state_nxt_s     = ST_SEND;
      tx_valid_nxt_s  = 1'b1;
      tx_data_nxt_s   = ln_data_s;
      tx_offset_nxt_s = cfg_offset;
      tx_size_nxt_s   = ln_size_s;
    end else if (pop_s) begin
      state_nxt_s     = ST_IDLE;
      tx_valid_nxt_s  = 1'b0;
      tx_data_nxt_s   = {ALGN_DATA_WIDTH{1'b0}};
      tx_offset_nxt_s = {OW{1'b0}};
      tx_size_nxt_s   = {SW{1'b0}};
    end else begin
      state_nxt_s = state_r;
    end
  end

  // Byte storage; contents are meaningless once pointers are reset.
  always_ff @(posedge clk) begin
    mem_r <= mem_nxt_s;
  end

  // Pointers, level, TX registers and status.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r     <= ST_IDLE;
      wr_ptr_r    <= {PW{1'b0}};
      rd_ptr_r    <= {PW{1'b0}};
      level_r     <= {LW{1'b0}};
      tx_valid_r  <= 1'b0;
      tx_data_r   <= {ALGN_DATA_WIDTH{1'b0}};
      tx_offset_r <= {OW{1'b0}};
      tx_size_r   <= {SW{1'b0}};
      cnt_r       <= {CNT_DROP_WIDTH{1'b0}};
      irq_r       <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      wr_ptr_r    <= wr_ptr_r + PW'(push_cnt_s);
      rd_ptr_r    <= rd_base_s;
      level_r     <= level_push_s - (pop_s ? LW'(tx_size_r) : {LW{1'b0}});
      tx_valid_r  <= tx_valid_nxt_s;
      tx_data_r   <= tx_data_nxt_s;
      tx_offset_r <= tx_offset_nxt_s;
      tx_size_r   <= tx_size_nxt_s;
      // A drop in the same cycle as a clear still counts.
      if (cfg_clr_cnt) begin
        cnt_r <= rx_drop_s ? {{(CNT_DROP_WIDTH-1){1'b0}}, 1'b1} : {CNT_DROP_WIDTH{1'b0}};
        irq_r <= rx_drop_s || tx_err_s;
      end else begin
        cnt_r <= (rx_drop_s && (cnt_r != {CNT_DROP_WIDTH{1'b1}})) ?
                 cnt_r + {{(CNT_DROP_WIDTH-1){1'b0}}, 1'b1} : cnt_r;
        irq_r <= irq_r || rx_drop_s || tx_err_s;
      end
    end
  end

  assign md_tx_valid  = tx_valid_r;
  assign md_tx_data   = tx_data_r;
  assign md_tx_offset = tx_offset_r;
  assign md_tx_size   = tx_size_r;
  assign cnt_drop     = cnt_r;
  assign buf_level    = level_r;
  assign irq          = irq_r;

endmodule
